// File: rtl/cv32e40p_lce_pkg.sv
// Shared types for the LCE watchdog-window monitor.
package cv32e40p_lce_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    ALARM    = 2'd2,
    LOCKOUT  = 2'd3
  } lce_state_e;

endpackage

// File: rtl/cv32e40p_lce_monitor_checker.sv
// Property checks for cv32e40p_lce_monitor: parameter sanity and exclusive
// window-counter controls.
module cv32e40p_lce_monitor_checker #(
  parameter int unsigned ALARM_MAX = 3
) (
  input logic clk,
  input logic rst_n,
  input logic init_o,
  input logic decrement_o
);

  if (ALARM_MAX < 1) begin : g_alarm_max_bad
    $error("cv32e40p_lce_monitor: ALARM_MAX must be at least 1");
  end

  a_init_dec_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(init_o && decrement_o)
  );

endmodule

// File: rtl/cv32e40p_lce_monitor.sv
// LCE watchdog-window controller: drives the window counter from the retirement
// stream and escalates counter alarms to an IRQ handshake and a sticky lockout.
module cv32e40p_lce_monitor
  import cv32e40p_lce_pkg::*;
#(
  parameter int unsigned ALARM_MAX   = 3,
  parameter int unsigned ALARM_CNT_W = $clog2(ALARM_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic                   instr_ret_i,
  input  logic                   checkpoint_i,
  input  logic                   alarm_i,
  input  logic                   irq_ack_i,
  output logic                   init_o,
  output logic                   decrement_o,
  output logic                   irq_req_o,
  output logic                   lockout_o,
  output logic [ALARM_CNT_W-1:0] alarm_cnt_o,
  output logic [1:0]             state_o
);

  localparam logic [ALARM_CNT_W-1:0] ALARM_MAX_C = ALARM_CNT_W'(ALARM_MAX);
  localparam logic [ALARM_CNT_W-1:0] CNT_ONE_C   = ALARM_CNT_W'(1);

  lce_state_e             state_r;
  lce_state_e             next_state_s;
  logic [ALARM_CNT_W-1:0] alarm_cnt_r;
  logic [ALARM_CNT_W-1:0] alarm_cnt_nxt_s;
  logic                   irq_req_r;
  logic                   lockout_r;
  logic                   init_s;
  logic                   decrement_s;

  // Next-state, alarm count update and window-counter control.
  always_comb begin
    next_state_s    = state_r;
    alarm_cnt_nxt_s = alarm_cnt_r;
    init_s          = 1'b1;
    decrement_s     = 1'b0;
    case (state_r)
      DISARMED: begin
        if (enable_i) begin
          next_state_s = ARMED;
        end else begin
          next_state_s = DISARMED;
        end
      end
      ARMED: begin
        init_s      = instr_ret_i &  checkpoint_i;
        decrement_s = instr_ret_i & ~checkpoint_i;
        // An alarm wins over a simultaneous disarm so it is never lost.
        if (alarm_i) begin
          next_state_s = ALARM;
          if (alarm_cnt_r != ALARM_MAX_C) begin
            alarm_cnt_nxt_s = alarm_cnt_r + CNT_ONE_C;
          end else begin
            alarm_cnt_nxt_s = alarm_cnt_r;
          end
        end else if (!enable_i) begin
          next_state_s = DISARMED;
        end else begin
          next_state_s = ARMED;
        end
      end
      ALARM: begin
        if (irq_ack_i) begin
          if (alarm_cnt_r == ALARM_MAX_C) begin
            next_state_s = LOCKOUT;
          end else if (enable_i) begin
            next_state_s = ARMED;
          end else begin
            next_state_s = DISARMED;
          end
        end else begin
          next_state_s = ALARM;
        end
      end
      LOCKOUT: begin
        next_state_s = LOCKOUT;
      end
      default: begin
        next_state_s = DISARMED;
      end
    endcase
  end

  // State, alarm count and the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DISARMED;
      alarm_cnt_r <= '0;
      irq_req_r   <= 1'b0;
      lockout_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      alarm_cnt_r <= alarm_cnt_nxt_s;
      irq_req_r   <= (next_state_s == ALARM);
      lockout_r   <= (next_state_s == LOCKOUT);
    end
  end

  assign init_o      = init_s;
  assign decrement_o = decrement_s;
  assign irq_req_o   = irq_req_r;
  assign lockout_o   = lockout_r;
  assign alarm_cnt_o = alarm_cnt_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_cv32e40p_lce_monitor.sv
// Directed bench: monitor paired with a behavioural window counter (WWDL=4).
module tb_cv32e40p_lce_monitor;

  logic       clk;
  logic       rst_n;
  logic       enable_i;
  logic       instr_ret_i;
  logic       checkpoint_i;
  logic       alarm_i;
  logic       irq_ack_i;
  logic       init_o;
  logic       decrement_o;
  logic       irq_req_o;
  logic       lockout_o;
  logic [1:0] alarm_cnt_o;
  logic [1:0] state_o;

  logic [2:0] wcnt_r;
  int         checks;
  int         errors;

  cv32e40p_lce_monitor #(.ALARM_MAX(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .instr_ret_i  (instr_ret_i),
    .checkpoint_i (checkpoint_i),
    .alarm_i      (alarm_i),
    .irq_ack_i    (irq_ack_i),
    .init_o       (init_o),
    .decrement_o  (decrement_o),
    .irq_req_o    (irq_req_o),
    .lockout_o    (lockout_o),
    .alarm_cnt_o  (alarm_cnt_o),
    .state_o      (state_o)
  );

  cv32e40p_lce_monitor_checker #(.ALARM_MAX(3)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_o      (init_o),
    .decrement_o (decrement_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural window counter: reload to 4, count down, alarm while at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_r <= 3'd4;
    end else if (init_o) begin
      wcnt_r <= 3'd4;
    end else if (decrement_o && (wcnt_r != 3'd0)) begin
      wcnt_r <= wcnt_r - 3'd1;
    end else begin
      wcnt_r <= wcnt_r;
    end
  end
  assign alarm_i = (wcnt_r == 3'd0);

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    enable_i     = 1'b0;
    instr_ret_i  = 1'b0;
    checkpoint_i = 1'b0;
    irq_ack_i    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   {2'd0, state_o},     4'd0);
    check({tag, "_init"},    {3'd0, init_o},      4'd1);
    check({tag, "_dec"},     {3'd0, decrement_o}, 4'd0);
    check({tag, "_irq"},     {3'd0, irq_req_o},   4'd0);
    check({tag, "_lockout"}, {3'd0, lockout_o},   4'd0);
    check({tag, "_cnt"},     {2'd0, alarm_cnt_o}, 4'd0);
  endtask

  // Arm already done; drain the window with 4 plain retires, then idle one cycle into ALARM.
  task automatic run_to_alarm();
    instr_ret_i = 1'b1;
    repeat (4) tick();
    instr_ret_i = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // 1: reset values, then window survives thanks to a checkpoint
    do_reset();
    check_reset_values("rst");
    enable_i = 1'b1;
    tick();
    check("t1_armed", {2'd0, state_o}, 4'd1);
    instr_ret_i = 1'b1;
    settle();
    check("t1_dec", {2'd0, decrement_o, init_o}, 4'b0010);
    repeat (3) tick();
    checkpoint_i = 1'b1;
    settle();
    check("t1_cp_init", {2'd0, decrement_o, init_o}, 4'b0001);
    tick();
    checkpoint_i = 1'b0;
    irq_ack_i    = 1'b1;
    repeat (3) tick();
    instr_ret_i = 1'b0;
    settle();
    check("t1_no_alarm", {3'd0, alarm_i}, 4'd0);
    check("t1_no_early_dec", {3'd0, decrement_o}, 4'd0);
    check("t1_ack_ignored", {2'd0, state_o}, 4'd1);
    irq_ack_i = 1'b0;

    // 2: four plain retires raise the alarm
    do_reset();
    enable_i = 1'b1;
    tick();
    instr_ret_i = 1'b1;
    repeat (4) tick();
    instr_ret_i = 1'b0;
    settle();
    check("t2_alarm_in", {3'd0, alarm_i}, 4'd1);
    check("t2_pre_state", {2'd0, state_o}, 4'd1);
    check("t2_pre_dec", {3'd0, decrement_o}, 4'd0);
    tick();
    check("t2_state", {2'd0, state_o}, 4'd2);
    check("t2_irq", {3'd0, irq_req_o}, 4'd1);
    check("t2_cnt", {2'd0, alarm_cnt_o}, 4'd1);
    check("t2_init", {2'd0, decrement_o, init_o}, 4'b0001);

    // 3: request held until ack, then back to ARMED
    instr_ret_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_hold%0d", i), {3'd0, irq_req_o}, 4'd1);
    end
    check("t3_alarm_dec", {2'd0, decrement_o, init_o}, 4'b0001);
    instr_ret_i = 1'b0;
    irq_ack_i   = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    check("t3_state", {2'd0, state_o}, 4'd1);
    check("t3_irq", {3'd0, irq_req_o}, 4'd0);
    check("t3_cnt", {2'd0, alarm_cnt_o}, 4'd1);

    // 4: second and third alarms, lockout, reset out of lockout
    run_to_alarm();
    check("t4_cnt2", {2'd0, alarm_cnt_o}, 4'd2);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    check("t4_rearm", {2'd0, state_o}, 4'd1);
    run_to_alarm();
    check("t4_cnt3", {2'd0, alarm_cnt_o}, 4'd3);
    check("t4_alarm3", {2'd0, state_o}, 4'd2);
    irq_ack_i = 1'b1;
    tick();
    check("t4_lock_state", {2'd0, state_o}, 4'd3);
    check("t4_lock", {2'd0, lockout_o, irq_req_o}, 4'b0010);
    instr_ret_i = 1'b1;
    repeat (3) tick();
    check("t4_lock_held", {2'd0, state_o}, 4'd3);
    check("t4_lock_out", {3'd0, lockout_o}, 4'd1);
    check("t4_lock_ctl", {2'd0, decrement_o, init_o}, 4'b0001);
    check("t4_lock_cnt", {2'd0, alarm_cnt_o}, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t4_rst");
    do_reset();

    // 5: checkpoint in the same cycle alarm_i rises
    enable_i = 1'b1;
    tick();
    instr_ret_i = 1'b1;
    repeat (4) tick();
    checkpoint_i = 1'b1;
    settle();
    check("t5_alarm_in", {3'd0, alarm_i}, 4'd1);
    check("t5_init", {2'd0, decrement_o, init_o}, 4'b0001);
    tick();
    instr_ret_i  = 1'b0;
    checkpoint_i = 1'b0;
    check("t5_state", {2'd0, state_o}, 4'd2);
    check("t5_irq", {3'd0, irq_req_o}, 4'd1);

    // 6: disable during ALARM, ack lands in DISARMED
    enable_i = 1'b0;
    tick();
    check("t6_irq_held", {3'd0, irq_req_o}, 4'd1);
    check("t6_state", {2'd0, state_o}, 4'd2);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    check("t6_disarmed", {2'd0, state_o}, 4'd0);
    check("t6_irq", {3'd0, irq_req_o}, 4'd0);
    tick();
    check("t6_init_held", {2'd0, decrement_o, init_o}, 4'b0001);
    check("t6_still_dis", {2'd0, state_o}, 4'd0);

    // 7: ack in the first ALARM cycle gives a one-cycle request
    do_reset();
    enable_i = 1'b1;
    tick();
    instr_ret_i = 1'b1;
    repeat (4) tick();
    instr_ret_i = 1'b0;
    irq_ack_i   = 1'b1;
    tick();
    check("t7_irq_one", {3'd0, irq_req_o}, 4'd1);
    tick();
    irq_ack_i = 1'b0;
    check("t7_irq_done", {3'd0, irq_req_o}, 4'd0);
    check("t7_state", {2'd0, state_o}, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
